// File: rtl/multicycle_control_unit.sv
// Main FSM and ALU decoder for the multicycle RISC-V core (lw, sw, R/I ALU ops, beq, jal).
// Define MCU_ILLEGAL_TRAP_EN to trap unsupported op/funct3 into a sticky HALT state.
module multicycle_control_unit #(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    output logic                 pcwrite,
    output logic                 adrsrc,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic [1:0]           resultsrc,
    output logic [1:0]           alusrca,
    output logic [1:0]           alusrcb,
    output logic                 regwrite,
    output logic [1:0]           immsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 instr_done,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
`ifdef MCU_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_q, state_d;
    aluop_t aluop;
    logic   branch;
    logic   pcupdate;
    logic   irwrite_s, memwrite_s, regwrite_s;
    logic   funct3_ok;

    assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = S_FETCH;
        aluop      = ALUOP_ADD;
        branch     = 1'b0;
        pcupdate   = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        adrsrc     = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_s = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcupdate  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_s = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_s = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                aluop   = ALUOP_FUNCT;
`ifdef MCU_ILLEGAL_TRAP_EN
                state_d = funct3_ok ? S_ALUWB : S_HALT;
`else
                state_d = S_ALUWB;
`endif
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alusrca    = 2'b10;
                aluop      = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal = 1'b1;
                state_d = S_HALT;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked combinationally so nothing commits during the reset cycle.
    assign pcwrite  = ~reset & ((branch & zero) | pcupdate);
    assign irwrite  = ~reset & irwrite_s;
    assign memwrite = ~reset & memwrite_s;
    assign regwrite = ~reset & regwrite_s;

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        alucontrol = '0;
        case (aluop)
            ALUOP_SUB: alucontrol = ALUCTRL_W'(3'b001);
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op[5] & funct7b5) ? ALUCTRL_W'(3'b001) : ALUCTRL_W'(3'b000);
                    3'b110:  alucontrol = ALUCTRL_W'(3'b011);
                    3'b111:  alucontrol = ALUCTRL_W'(3'b010);
                    default: alucontrol = ALUCTRL_W'(3'b000);
                endcase
            end
            default: alucontrol = ALUCTRL_W'(3'b000);
        endcase
    end

    // Referenced so the trap-disabled build has no unused-signal warning.
    logic unused_ok;
    assign unused_ok = funct3_ok;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: directed instruction sequences push
// expected per-cycle outputs, a negedge monitor pops and compares.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, instr_done, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALUCTRL_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .regwrite(regwrite), .immsrc(immsrc), .alucontrol(alucontrol),
        .instr_done(instr_done), .illegal(illegal)
    );

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic [1:0] immsrc;
        logic [2:0] alucontrol;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    typedef struct {
        string tag;
        outs_t exp;
    } sb_t;

    typedef enum {
        T_FETCH, T_DECODE, T_NOP, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_HALT
    } tstate_e;

    typedef enum { K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_BAD } kind_e;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (pcw adr memw irw res[2] a[2] b[2] regw imm[2] alu[3] done ill)",
                     tag, got, exp);
        end
    endtask

    // Expected per-state outputs, written out from the control table.
    function automatic outs_t mk(tstate_e st, logic [2:0] alu, logic [1:0] imm, logic rst, logic z);
        outs_t e = '0;
        e.immsrc     = imm;
        e.alucontrol = alu;
        case (st)
            T_FETCH:    begin e.irwrite = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10; e.pcwrite = 1; end
            T_DECODE:   begin e.alusrca = 2'b01; e.alusrcb = 2'b01; end
            T_NOP:      begin e.alusrca = 2'b01; e.alusrcb = 2'b01; e.instr_done = 1; end
            T_MEMADR:   begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
            T_MEMREAD:  begin e.adrsrc = 1; end
            T_MEMWB:    begin e.resultsrc = 2'b01; e.regwrite = 1; e.instr_done = 1; end
            T_MEMWRITE: begin e.adrsrc = 1; e.memwrite = 1; e.instr_done = 1; end
            T_EXECR:    begin e.alusrca = 2'b10; end
            T_EXECI:    begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
            T_ALUWB:    begin e.regwrite = 1; e.instr_done = 1; end
            T_BEQ:      begin e.alusrca = 2'b10; e.pcwrite = z; e.instr_done = 1; end
            T_JAL:      begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1; end
            T_HALT:     begin e.illegal = 1; end
            default:    ;
        endcase
        if (rst) begin
            e.pcwrite = 0; e.memwrite = 0; e.irwrite = 0; e.regwrite = 0;
        end
        return e;
    endfunction

    task automatic cyc(input string tag, input tstate_e st, input logic [2:0] alu, input logic [1:0] imm);
        sb_t s;
        s.tag = tag;
        s.exp = mk(st, alu, imm, reset, zero);
        sb_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic [1:0] imm, input kind_e k, input logic [2:0] alu);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        cyc({tag, ".fetch"}, T_FETCH, 3'b000, imm);
        if (k == K_BAD) begin
`ifdef MCU_ILLEGAL_TRAP_EN
            cyc({tag, ".decode"}, T_DECODE, 3'b000, imm);
`else
            cyc({tag, ".nop"}, T_NOP, 3'b000, imm);
`endif
            return;
        end
        cyc({tag, ".decode"}, T_DECODE, 3'b000, imm);
        case (k)
            K_LW: begin
                cyc({tag, ".memadr"}, T_MEMADR, 3'b000, imm);
                cyc({tag, ".memread"}, T_MEMREAD, 3'b000, imm);
                cyc({tag, ".memwb"}, T_MEMWB, 3'b000, imm);
            end
            K_SW: begin
                cyc({tag, ".memadr"}, T_MEMADR, 3'b000, imm);
                cyc({tag, ".memwrite"}, T_MEMWRITE, 3'b000, imm);
            end
            K_R: begin
                cyc({tag, ".execr"}, T_EXECR, alu, imm);
                cyc({tag, ".aluwb"}, T_ALUWB, 3'b000, imm);
            end
            K_I: begin
                cyc({tag, ".execi"}, T_EXECI, alu, imm);
                cyc({tag, ".aluwb"}, T_ALUWB, 3'b000, imm);
            end
            K_BEQ: cyc({tag, ".beq"}, T_BEQ, 3'b001, imm);
            K_JAL: begin
                cyc({tag, ".jal"}, T_JAL, 3'b000, imm);
                cyc({tag, ".aluwb"}, T_ALUWB, 3'b000, imm);
            end
            default: ;
        endcase
    endtask

    task automatic halt_then_reset(input string tag, input int n, input logic [1:0] imm);
        for (int i = 0; i < n; i++) begin
            zero = i[0];
            cyc({tag, ".halt"}, T_HALT, 3'b000, imm);
        end
        reset = 1'b1;
        cyc({tag, ".halt_rst"}, T_HALT, 3'b000, imm);
        reset = 1'b0;
    endtask

    initial begin : monitor
        sb_t   s;
        outs_t got;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                s   = sb_q.pop_front();
                got = '{pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
                        regwrite, immsrc, alucontrol, instr_done, illegal};
                check(s.tag, got, s.exp);
            end
        end
    end

    initial begin : stim
        reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc("reset", T_FETCH, 3'b000, 2'b00);
        reset = 1'b0;

        run("r_add",  7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, K_R,   3'b000);
        run("r_sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, K_R,   3'b001);
        run("r_or",   7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, K_R,   3'b011);
        run("r_and",  7'b0110011, 3'b111, 1'b1, 1'b0, 2'b00, K_R,   3'b010);
        run("i_add",  7'b0010011, 3'b000, 1'b1, 1'b1, 2'b00, K_I,   3'b000);
        run("i_or",   7'b0010011, 3'b110, 1'b0, 1'b0, 2'b00, K_I,   3'b011);
        run("lw",     7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, K_LW,  3'b000);
        run("beq_t",  7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, K_BEQ, 3'b001);
        run("beq_nt", 7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, K_BEQ, 3'b001);
        run("jal",    7'b1101111, 3'b000, 1'b0, 1'b1, 2'b11, K_JAL, 3'b000);
        run("sw",     7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, K_SW,  3'b000);

        // Reset lands in the MEMWRITE cycle of a store.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        cyc("sw_rst.fetch", T_FETCH, 3'b000, 2'b01);
        cyc("sw_rst.decode", T_DECODE, 3'b000, 2'b01);
        cyc("sw_rst.memadr", T_MEMADR, 3'b000, 2'b01);
        reset = 1'b1;
        cyc("sw_rst.memwrite", T_MEMWRITE, 3'b000, 2'b01);
        reset = 1'b0;
        run("after_rst", 7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, K_R, 3'b001);

`ifdef MCU_ILLEGAL_TRAP_EN
        op = 7'b0110011; funct3 = 3'b001; funct7b5 = 1'b0; zero = 1'b0;
        cyc("bad_f3.fetch", T_FETCH, 3'b000, 2'b00);
        cyc("bad_f3.decode", T_DECODE, 3'b000, 2'b00);
        cyc("bad_f3.execr", T_EXECR, 3'b000, 2'b00);
        halt_then_reset("bad_f3", 3, 2'b00);
        run("bad_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, K_BAD, 3'b000);
        halt_then_reset("bad_op", 20, 2'b00);
`else
        run("bad_f3", 7'b0110011, 3'b001, 1'b1, 1'b0, 2'b00, K_R, 3'b000);
        run("bad_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00, K_BAD, 3'b000);
`endif
        run("recover", 7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, K_LW, 3'b000);

        @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
